// File: rtl/lock_pkg.sv
// Shared constants and state encoding for the code-lock controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lock_pkg;

  localparam int UNLOCK_CYCLES_DEF  = 8;
  localparam int MAX_FAIL_DEF       = 3;
  localparam int LOCKOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a zero flag; shared by the OPEN and LOCKOUT dwell periods.
// Latency: load/decrement visible one cycle after the edge that samples them.
// Backpressure: none; holds at zero instead of underflowing.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/lock_ctrl.sv
// Code-lock FSM: evaluates comparator flags on a try strobe, opens, counts failures.
// Latency: outputs change one cycle after the try cycle; all outputs are Moore-decoded.
// Backpressure: try is only sampled in IDLE (busy=0); tries in other states are dropped.
// Optional: define LOCK_CTRL_LOCKOUT_EN to add the LOCKOUT state and alarm output.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int UNLOCK_CYCLES  = UNLOCK_CYCLES_DEF,
  parameter int MAX_FAIL       = MAX_FAIL_DEF,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       try,
  input  logic       equal,
  input  logic       not_equal,
  output logic       unlocked,
  output logic       err,
  output logic       alarm,
  output logic       busy,
  output logic [1:0] fail_cnt
);

  // Timer must hold the longer of the two dwell periods.
  localparam int         TW         = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam logic [1:0] MAX_FAIL_W = 2'(MAX_FAIL);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_fail_cnt;
  logic [1:0]      w_fail_nxt;
  logic [1:0]      w_fail_inc;
  logic            w_match;
  logic            w_tmr_load;
  logic [TW-1:0]   w_tmr_value;
  logic            w_tmr_en;
  logic            w_tmr_zero;

  // A match needs both flags consistent; every other combination is a failure.
  assign w_match    = equal & ~not_equal;
  assign w_fail_inc = (r_fail_cnt == MAX_FAIL_W) ? r_fail_cnt : (r_fail_cnt + 2'd1);

  lock_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .i_en    (w_tmr_en),
    .o_zero  (w_tmr_zero)
  );

  // State and failure counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fail_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_fail_cnt <= w_fail_nxt;
    end
  end

  // Next-state, failure count and timer control.
  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = r_fail_cnt;
    w_tmr_load  = 1'b0;
    w_tmr_value = '0;
    w_tmr_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (try) begin
          if (w_match) begin
            w_state_nxt = ST_OPEN;
            w_fail_nxt  = 2'd0;
            w_tmr_load  = 1'b1;
            w_tmr_value = TW'(UNLOCK_CYCLES - 1);
          end else begin
            w_fail_nxt  = w_fail_inc;
            w_state_nxt = ST_FAIL;
`ifdef LOCK_CTRL_LOCKOUT_EN
            if (w_fail_inc == MAX_FAIL_W) begin
              w_state_nxt = ST_LOCKOUT;
              w_tmr_load  = 1'b1;
              w_tmr_value = TW'(LOCKOUT_CYCLES - 1);
            end
`endif
          end
        end
      end
      ST_OPEN: begin
        if (w_tmr_zero) w_state_nxt = ST_IDLE;
        else            w_tmr_en    = 1'b1;
      end
      ST_FAIL: begin
        w_state_nxt = ST_IDLE;
      end
`ifdef LOCK_CTRL_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_IDLE;
          w_fail_nxt  = 2'd0;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign unlocked = (r_state == ST_OPEN);
  assign busy     = (r_state != ST_IDLE);
  assign fail_cnt = r_fail_cnt;

`ifdef LOCK_CTRL_LOCKOUT_EN
  logic r_lock_first;

  // Flags the first lockout cycle so the triggering failure still pulses err.
  always_ff @(posedge clk) begin
    if (rst) r_lock_first <= 1'b0;
    else     r_lock_first <= (r_state == ST_IDLE) && (w_state_nxt == ST_LOCKOUT);
  end

  assign err   = (r_state == ST_FAIL) | r_lock_first;
  assign alarm = (r_state == ST_LOCKOUT);
`else
  assign err   = (r_state == ST_FAIL);
  assign alarm = 1'b0;
`endif

endmodule
